// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet-style Manchester transmit/receive pair.
package eth_tx_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0] SFD_BYTE      = 8'hAB;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StIfg
    } tx_state_t;

    // Line level for one half of a Manchester bit: a 1 is low-then-high, a 0 is high-then-low.
    function automatic logic manchester_level(input logic bit_val, input logic second_half);
        return second_half ? bit_val : ~bit_val;
    endfunction

endpackage

// File: rtl/half_bit_timer.sv
// Half-bit timer: counts clocks within a half-bit and tracks which half of the bit is active.
module half_bit_timer #(
    parameter int unsigned HALF_BIT_CLKS = 5
) (
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic phase_o,
    output logic half_done_o,
    output logic bit_done_o
);

    localparam int unsigned CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign half_done_o = en_i && (cnt_q == LAST);
    assign bit_done_o  = half_done_o && phase_q;
    assign phase_o     = phase_q;

    // Next count: clear wins, otherwise wrap at the half-bit length and flip the phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/manchester_transmitter.sv
// Manchester transmitter: preamble + SFD + payload drained from a packet store, then an idle gap.
module manchester_transmitter
    import eth_tx_pkg::*;
#(
    parameter int unsigned HALF_BIT_CLKS = 5,
    parameter int unsigned PRE_BYTES     = 7,
    parameter int unsigned IFG_CLKS      = 20
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ready,
    input  logic       empty,
    input  logic [7:0] r_data,
    output logic       r_en,
    output logic       Ethernet_Out,
    output logic       busy
);

    localparam int unsigned PW = (PRE_BYTES > 1) ? $clog2(PRE_BYTES) : 1;
    localparam int unsigned IW = (IFG_CLKS > 1) ? $clog2(IFG_CLKS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_BYTES - 1);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CLKS - 1);

    tx_state_t     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [IW-1:0] ifg_cnt_q, ifg_cnt_d;
    logic [7:0]    next_byte_q, next_byte_d;
    logic          have_next_q, have_next_d;
    logic          r_en_q, r_en_d;
    logic          line_q, line_d;
    logic          busy_q, busy_d;

    logic tmr_clear, tmr_en, phase, half_done, bit_done, start;

    half_bit_timer #(
        .HALF_BIT_CLKS(HALF_BIT_CLKS)
    ) u_timer (
        .clk_i      (clk),
        .n_rst_i    (n_rst),
        .clear_i    (tmr_clear),
        .en_i       (tmr_en),
        .phase_o    (phase),
        .half_done_o(half_done),
        .bit_done_o (bit_done)
    );

    // Next-state, shifter, prefetch and registered-output logic.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        pre_cnt_d   = pre_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        next_byte_d = next_byte_q;
        have_next_d = have_next_q;
        r_en_d      = 1'b0;
        line_d      = line_q;
        busy_d      = busy_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;
        start       = 1'b0;

        // The source presents the popped byte one clock after the strobe.
        if (r_en_q) begin
            next_byte_d = r_data;
        end

        unique case (state_q)
            StIdle: begin
                line_d    = 1'b1;
                busy_d    = 1'b0;
                tmr_clear = 1'b1;
                start     = ready;
            end
            StIfg: begin
                line_d    = 1'b1;
                tmr_clear = 1'b1;
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    ifg_cnt_d = '0;
                    // Passing through idle: a waiting packet starts on this very edge.
                    start     = ready;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IW'(1);
                end
            end
            StPreamble, StSfd, StData: begin
                tmr_en = 1'b1;
                if (half_done && !phase) begin
                    line_d = manchester_level(shift_q[7], 1'b1);
                    // Prefetch at the start of bit 0's second half, ahead of the byte boundary.
                    if (bit_q == 3'd0 && state_q != StPreamble) begin
                        r_en_d      = ~empty;
                        have_next_d = ~empty;
                    end
                end else if (bit_done) begin
                    if (bit_q != 3'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                        line_d  = manchester_level(shift_q[6], 1'b0);
                    end else if (state_q == StPreamble) begin
                        bit_d = 3'd7;
                        if (pre_cnt_q == PRE_LAST) begin
                            state_d   = StSfd;
                            shift_d   = SFD_BYTE;
                            pre_cnt_d = '0;
                        end else begin
                            shift_d   = PREAMBLE_BYTE;
                            pre_cnt_d = pre_cnt_q + PW'(1);
                        end
                        line_d = manchester_level(shift_d[7], 1'b0);
                    end else if (have_next_q) begin
                        state_d     = StData;
                        shift_d     = next_byte_q;
                        bit_d       = 3'd7;
                        have_next_d = 1'b0;
                        line_d      = manchester_level(next_byte_q[7], 1'b0);
                    end else begin
                        state_d   = StIfg;
                        ifg_cnt_d = '0;
                        line_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (start) begin
            state_d     = StPreamble;
            shift_d     = PREAMBLE_BYTE;
            bit_d       = 3'd7;
            pre_cnt_d   = '0;
            have_next_d = 1'b0;
            busy_d      = 1'b1;
            line_d      = manchester_level(PREAMBLE_BYTE[7], 1'b0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_q       <= '0;
            pre_cnt_q   <= '0;
            ifg_cnt_q   <= '0;
            next_byte_q <= '0;
            have_next_q <= 1'b0;
            r_en_q      <= 1'b0;
            line_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            pre_cnt_q   <= pre_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            next_byte_q <= next_byte_d;
            have_next_q <= have_next_d;
            r_en_q      <= r_en_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
        end
    end

    assign r_en         = r_en_q;
    assign Ethernet_Out = line_q;
    assign busy         = busy_q;

endmodule

// File: doc/manchester_transmitter.md
# manchester_transmitter

Transmit-side counterpart to the packet storage receiver. Waits for a stored packet, then drains it byte by byte through a read handshake. Prepends 7 preamble bytes and the SFD, and serialises everything MSB-first as a 10 Mb/s-style Manchester stream on a single wire. Ends each packet with a fixed interpacket gap at the idle-high level.

## Interface
- HALF_BIT_CLKS, 5: clocks per Manchester half-bit (one bit = 2×HALF_BIT_CLKS).
- PRE_BYTES, 7: preamble byte count (value 8'hAA each) before SFD.
- IFG_CLKS, 20: minimum clocks of idle-high after the last half-bit.
- clk  in  1  single system clock, rising-edge.
- n_rst  in  1  asynchronous, active-low reset.
- ready  in  1  high when at least one complete packet is stored.
- empty  in  1  high when the byte source holds no further bytes of the current packet.
- r_data  in  8  byte from source, valid one clock after r_en.
- r_en  out  1  one-clock pop strobe to the byte source.
- Ethernet_Out  out  1  Manchester line, idle = 1.
- busy  out  1  high from packet start through end of IFG.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, IFG.
- IDLE: Ethernet_Out=1. ready=1 sampled → PREAMBLE, load 8'hAA, preamble counter=0.
- Encoding per bit, MSB (bit 7) first:
  - 1 → low half then high half.
  - 0 → high half then low half.
- Half-bit timer counts 0..HALF_BIT_CLKS-1; bit counter 7..0; byte ends after bit 0 second half.
- PREAMBLE: after PRE_BYTES bytes → SFD, load 8'hAB.
- Prefetch: in every byte of SFD and DATA, on the first clock of bit 0's second half:
  - empty=0 → assert r_en for exactly one clock; capture r_data the next clock into next_byte; set have_next.
  - empty=1 → no r_en; clear have_next.
- Byte end in SFD/DATA: have_next=1 → DATA, shift next_byte in; have_next=0 → IFG.
  - SFD with empty payload (empty at SFD prefetch) goes straight to IFG; legal.
- IFG: Ethernet_Out=1 for IFG_CLKS clocks, then IDLE.
  - ready is ignored until IDLE is re-entered.
  - With ready still high, the next packet starts on the first IDLE clock.
- r_en never asserts outside SFD/DATA; at most one r_en per transmitted data byte.
- ready or empty changes outside the prefetch clock are ignored.

## Timing
- Reset values (async on n_rst=0):
  - Ethernet_Out=1, r_en=0, busy=0.
  - state=IDLE, all counters 0, have_next=0.
- All outputs are registered.
- Start latency: edge sampling ready=1 drives the first half-bit (preamble bit7=1 → 0) and busy=1 on that same edge.
- Each half-bit lasts exactly HALF_BIT_CLKS clocks; byte = 16×HALF_BIT_CLKS = 80 clocks by default.
- Header = (PRE_BYTES+1)×80 = 640 clocks; no extra gap or glitch between bytes.
- Packet of N payload bytes: busy high for 640 + 80N + IFG_CLKS clocks.
- r_en pulse lands 5 clocks before the byte boundary; r_data must be valid on the edge after r_en.
- Reset mid-packet: line returns to 1 immediately; no r_en is issued; the source is not rewound.

## Structure
- Package eth_tx_pkg:
  - PREAMBLE_BYTE = 8'hAA, SFD_BYTE = 8'hAB.
  - State enum tx_state_t.
  - Shared with the receiver.
- Sub-module half_bit_timer:
  - Parameterised counter with clear and enable.
  - Emits half_done and bit_done strobes.
- Top holds the FSM, shift register, next_byte/have_next and the output register.

## Test plan
- Reset: hold n_rst=0 mid-random stimulus → Ethernet_Out=1, r_en=0, busy=0 immediately; remain so with ready=0.
- One-byte packet 8'h0F, empty rises after the pop:
  - Line shows 7×AA, AB, 0F in correct half-bit order, 80 clocks each.
  - Exactly one r_en; busy drops 20 clocks after the final half-bit.
- Zero-payload: empty=1 throughout → preamble+SFD only, zero r_en, IFG of 20 high clocks.
- Back-to-back packets 4 bytes {FB,FB,A3,F0} each, ready held high:
  - Second preamble starts exactly 20 clocks after the first packet's last half-bit.
  - 8 r_en pulses total.
- Long packet 1500 bytes of 8'hFB:
  - Exactly 1500 r_en pulses, each 5 clocks before a byte boundary.
  - Decoded line matches the source bytes.
- Loopback: feed Ethernet_Out into the packet storage receiver → stored bytes read back equal the transmitted payload.
